// File: rtl/controlador_fetch.sv
// Instruction fetch sequencer: owns the PC, reads big-endian instruction memory, buffers words in a FIFO for decode.
// Optional FETCH_PERF_EN adds saturating fetched/stall performance counters.
module controlador_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_BYTES = 1000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_dir,
  input  logic [31:0] mem_inst,
  input  logic        fetch_en,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        fault,
  output logic [1:0]  fault_code
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [31:0]   PC_MAX  = 32'(MEM_BYTES - 4);

  localparam logic [1:0] CODE_NONE      = 2'b00;
  localparam logic [1:0] CODE_MISALIGN  = 2'b01;
  localparam logic [1:0] CODE_OUT_RANGE = 2'b10;

  logic [31:0]   pc;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [31:0]   buf_inst [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];

  logic in_range;
  logic empty;
  logic full;
  logic pop;
  logic fetch_ok;

  assign mem_dir  = pc;
  assign in_range = (pc <= PC_MAX);
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);

  // A redirect cycle never transfers, so decode cannot consume an entry that is being flushed.
  assign if_valid = ~empty & ~redir_valid;
  assign pop      = if_valid & if_ready;
  assign fetch_ok = fetch_en & ~fault & ~redir_valid & in_range & (~full | pop);

  assign if_inst = empty ? 32'h0 : buf_inst[rptr];
  assign if_pc   = empty ? 32'h0 : buf_pc[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      fault      <= 1'b0;
      fault_code <= CODE_NONE;
    end else if (redir_valid) begin
      pc <= redir_pc;
      if (redir_pc[1:0] != 2'b00) begin
        fault      <= 1'b1;
        fault_code <= CODE_MISALIGN;
      end else if (redir_pc > PC_MAX) begin
        fault      <= 1'b1;
        fault_code <= CODE_OUT_RANGE;
      end else begin
        fault      <= 1'b0;
        fault_code <= CODE_NONE;
      end
    end else begin
      if (fetch_ok) begin
        pc <= pc + 32'd4;
      end
      // Only a clean PC can run off the end; an existing fault keeps its original cause.
      if (~fault & ~in_range) begin
        fault      <= 1'b1;
        fault_code <= CODE_OUT_RANGE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redir_valid) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (fetch_ok) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({fetch_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fetch_ok) begin
      buf_inst[wptr] <= mem_inst;
      buf_pc[wptr]   <= pc;
    end
  end

`ifdef FETCH_PERF_EN
  logic stall_cond;

  assign stall_cond = fetch_en & ~fault & ~redir_valid & in_range & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (fetch_ok && perf_fetched != 32'hFFFF_FFFF) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (stall_cond && perf_stall != 32'hFFFF_FFFF) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
